alu_cmd_sequencer: RTL and testbench

- Runs one ALU command from start to finish for the system controller.
- Fetches operands A/B from the register file, issues the ALU function, and waits for the result.
- Pushes the result into the TX FIFO as low byte then high byte, respecting fifo_full.
- The system controller sends only start/fun/use_regs and waits for done, so it no longer carries ALU/regfile sequencing itself.

---
 rtl/alu_cmd_sequencer_if.sv | 39 +++
 rtl/alu_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, regfile, ALU and TX FIFO signals of the ALU command sequencer
interface alu_cmd_sequencer_if #(
  parameter int data_width    = 8,
  parameter int address_width = 3,
  parameter int alu_width     = 16
);
  logic                     start;
  logic [3:0]               fun;
  logic                     use_regs;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [address_width-1:0] rf_address;
  logic                     rf_rd_en;
  logic [data_width-1:0]    rf_rddata;
  logic                     rf_rddata_valid;
  logic [data_width-1:0]    alu_op_a;
  logic [data_width-1:0]    alu_op_b;
  logic [3:0]               alu_fun;
  logic                     alu_en;
  logic                     alu_clk_en;
  logic [alu_width-1:0]     alu_out;
  logic                     alu_out_valid;
  logic [data_width-1:0]    fifo_wr_data;
  logic                     fifo_wr_inc;
  logic                     fifo_full;

  modport master (
    input  start, fun, use_regs, rf_rddata, rf_rddata_valid, alu_out, alu_out_valid, fifo_full,
    output busy, done, err, rf_address, rf_rd_en, alu_op_a, alu_op_b, alu_fun, alu_en,
           alu_clk_en, fifo_wr_data, fifo_wr_inc
  );

  modport slave (
    output start, fun, use_regs, rf_rddata, rf_rddata_valid, alu_out, alu_out_valid, fifo_full,
    input  busy, done, err, rf_address, rf_rd_en, alu_op_a, alu_op_b, alu_fun, alu_en,
           alu_clk_en, fifo_wr_data, fifo_wr_inc
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - runs one ALU command: operand fetch, issue, result capture, byte-wise TX FIFO push
// Optional wait watchdog on regfile/ALU responses is enabled by defining ALU_TIMEOUT_EN.
module alu_cmd_sequencer #(
  parameter int data_width    = 8,
  parameter int address_width = 3,
  parameter int alu_width     = 16,
  parameter int OPA_ADDR      = 0,
  parameter int OPB_ADDR      = 1,
  parameter int TIMEOUT       = 15
) (
  input  logic                clk,
  input  logic                reset,
  alu_cmd_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WAIT_RES, PUSH_LO, PUSH_HI} state_t;
  localparam bit two_bytes = (alu_width > data_width);

  state_t state, next_state;
  logic   abort, rd_accept, timeout_hit;

  logic                     busy_q, done_q, err_q, rf_rd_en_q, alu_en_q, alu_clk_en_q, wr_inc_q;
  logic                     busy_d, done_d, err_d, rf_rd_en_d, alu_en_d, alu_clk_en_d, wr_inc_d;
  logic [address_width-1:0] rf_address_q, rf_address_d;
  logic [data_width-1:0]    op_a_q, op_b_q, wr_data_q;
  logic [data_width-1:0]    op_a_d, op_b_d, wr_data_d;
  logic [3:0]               fun_q, fun_d;
  logic [alu_width-1:0]     result_q, result_d;
  logic [2*data_width-1:0]  result_ext;

  // Read data only counts while the request is held, so the stale beat of
  // operand A arriving during the inter-read gap is never taken as operand B.
  assign rd_accept = bus.rf_rddata_valid && rf_rd_en_q;

`ifdef ALU_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       waiting;
  assign waiting = state inside {RD_A, RD_B, WAIT_RES};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   wait_cnt <= '0;
    else if (next_state != state) wait_cnt <= '0;
    else if (waiting)             wait_cnt <= wait_cnt + 4'd1;
  end
  assign timeout_hit = waiting && (wait_cnt == 4'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_address_q <= '0;
      alu_en_q     <= 1'b0;
      alu_clk_en_q <= 1'b0;
      wr_inc_q     <= 1'b0;
      wr_data_q    <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      fun_q        <= '0;
      result_q     <= '0;
    end else begin
      state        <= next_state;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_address_q <= rf_address_d;
      alu_en_q     <= alu_en_d;
      alu_clk_en_q <= alu_clk_en_d;
      wr_inc_q     <= wr_inc_d;
      wr_data_q    <= wr_data_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      fun_q        <= fun_d;
      result_q     <= result_d;
    end
  end

  // A push state is left on the edge after its strobe was issued.
  always_comb begin
    next_state = state;
    abort      = 1'b0;
    unique case (state)
      IDLE:     if (bus.start) next_state = bus.use_regs ? RD_A : EXEC;
      RD_A:     if (rd_accept) next_state = RD_B;
                else if (timeout_hit) abort = 1'b1;
      RD_B:     if (rd_accept) next_state = EXEC;
                else if (timeout_hit) abort = 1'b1;
      EXEC:     next_state = WAIT_RES;
      WAIT_RES: if (bus.alu_out_valid) next_state = PUSH_LO;
                else if (timeout_hit) abort = 1'b1;
      PUSH_LO:  if (wr_inc_q) next_state = two_bytes ? PUSH_HI : IDLE;
      PUSH_HI:  if (wr_inc_q) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_comb begin
    fun_d        = (state == IDLE && bus.start) ? bus.fun : fun_q;
    op_a_d       = (state == RD_A && rd_accept) ? bus.rf_rddata : op_a_q;
    op_b_d       = (state == RD_B && rd_accept) ? bus.rf_rddata : op_b_q;
    result_d     = (state == WAIT_RES && bus.alu_out_valid) ? bus.alu_out : result_q;
    result_ext   = (2*data_width)'(result_d);
    busy_d       = (next_state != IDLE);
    done_d       = (next_state == IDLE) && (state inside {PUSH_LO, PUSH_HI});
    err_d        = abort;
    rf_rd_en_d   = (next_state == RD_A) || (next_state == RD_B && state == RD_B);
    rf_address_d = '0;
    if (next_state == RD_A) rf_address_d = address_width'(OPA_ADDR);
    if (next_state == RD_B) rf_address_d = address_width'(OPB_ADDR);
    alu_en_d     = (next_state == EXEC);
    alu_clk_en_d = (next_state inside {EXEC, WAIT_RES});
    wr_inc_d     = (next_state inside {PUSH_LO, PUSH_HI}) && !bus.fifo_full;
    wr_data_d    = '0;
    if (wr_inc_d)
      wr_data_d = (next_state == PUSH_HI) ? result_ext[2*data_width-1:data_width]
                                          : result_ext[data_width-1:0];
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rf_rd_en     = rf_rd_en_q;
  assign bus.rf_address   = rf_address_q;
  assign bus.alu_op_a     = op_a_q;
  assign bus.alu_op_b     = op_b_q;
  assign bus.alu_fun      = fun_q;
  assign bus.alu_en       = alu_en_q;
  assign bus.alu_clk_en   = alu_clk_en_q;
  assign bus.fifo_wr_inc  = wr_inc_q;
  assign bus.fifo_wr_data = wr_data_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with regfile, ALU and FIFO models
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.data_width(8), .address_width(3), .alu_width(16)) bus ();

  alu_cmd_sequencer #(
    .data_width(8), .address_width(3), .alu_width(16),
    .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Regfile answers one cycle after a sampled read request.
  logic [7:0] rf_mem [8];
  always @(posedge clk) begin
    bus.rf_rddata_valid <= bus.rf_rd_en;
    bus.rf_rddata       <= rf_mem[bus.rf_address];
  end

  // ALU returns alu_res alu_lat cycles after the issue strobe.
  logic [3:0]  en_sr = '0;
  logic [15:0] alu_res = '0;
  int          alu_lat = 1;
  logic        alu_never = 1'b0;
  always @(posedge clk) en_sr <= {en_sr[2:0], bus.alu_en};
  assign bus.alu_out       = alu_res;
  assign bus.alu_out_valid = !alu_never && en_sr[alu_lat-1];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rd_rises = 0;
  logic rd_prev = 1'b0;
  logic [7:0] wr_byte[$];
  int wr_cyc[$];
  int done_cyc[$];
  int err_cyc[$];
  int en_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at8(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? {24'h0, q[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ati(input int q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] out_vec();
    return {2'b00, bus.busy, bus.done, bus.err, bus.rf_rd_en, bus.rf_address, bus.alu_en,
            bus.alu_clk_en, bus.fifo_wr_inc, bus.alu_fun, bus.fifo_wr_data, bus.alu_op_a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.fifo_wr_inc) begin
      wr_byte.push_back(bus.fifo_wr_data);
      wr_cyc.push_back(cyc);
    end
    if (bus.done) done_cyc.push_back(cyc);
    if (bus.err) err_cyc.push_back(cyc);
    if (bus.alu_en) en_cyc.push_back(cyc);
    if (bus.rf_rd_en && !rd_prev) rd_rises++;
    rd_prev = bus.rf_rd_en;
  endtask

  task automatic clear_logs();
    cyc = 0;
    rd_rises = 0;
    wr_byte.delete();
    wr_cyc.delete();
    done_cyc.delete();
    err_cyc.delete();
    en_cyc.delete();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.start     = 1'b0;
    bus.fun       = 4'h0;
    bus.use_regs  = 1'b0;
    bus.fifo_full = 1'b0;
    rf_mem = '{8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state
    repeat (3) tick();
    check("reset_outputs", out_vec(), 32'h0);
    check("reset_op_b", {24'h0, bus.alu_op_b}, 32'h0);
    reset = 1'b1;
    tick();

    // Regfile fetch: 5 + 3 = 8
    clear_logs();
    alu_res = 16'h0008; alu_lat = 1;
    bus.start = 1'b1; bus.fun = 4'h0; bus.use_regs = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 60 && done_cyc.size() == 0; i++) tick();
    check("fetch_op_a", {24'h0, bus.alu_op_a}, 32'h05);
    check("fetch_op_b", {24'h0, bus.alu_op_b}, 32'h03);
    check("fetch_alu_en_count", en_cyc.size(), 1);
    check("fetch_rd_bursts", rd_rises, 2);
    check("fetch_nbytes", wr_byte.size(), 2);
    check("fetch_byte0", at8(wr_byte, 0), 32'h08);
    check("fetch_byte1", at8(wr_byte, 1), 32'h00);
    check("fetch_done_count", done_cyc.size(), 1);
    check("fetch_busy_at_done", {31'h0, bus.busy}, 32'h0);

    // Held operands, fun=2, ALU latency 2: done at k+6
    clear_logs();
    alu_res = 16'h1234; alu_lat = 2;
    bus.start = 1'b1; bus.fun = 4'h2; bus.use_regs = 1'b0;
    tick();
    bus.start = 1'b0;
    check("lat2_alu_en_c1", {31'h0, bus.alu_en}, 32'h1);
    check("lat2_alu_fun", {28'h0, bus.alu_fun}, 32'h2);
    check("lat2_clk_en_c1", {31'h0, bus.alu_clk_en}, 32'h1);
    run_to(9);
    check("lat2_no_rd", rd_rises, 0);
    check("lat2_byte0", at8(wr_byte, 0), 32'h34);
    check("lat2_byte1", at8(wr_byte, 1), 32'h12);
    check("lat2_push_cyc0", ati(wr_cyc, 0), 32'd4);
    check("lat2_push_cyc1", ati(wr_cyc, 1), 32'd5);
    check("lat2_done_cyc", ati(done_cyc, 0), 32'd6);
    check("lat2_held_op_a", {24'h0, bus.alu_op_a}, 32'h05);

    // FIFO full for 5 cycles on entry to PUSH_LO
    clear_logs();
    alu_res = 16'hABCD; alu_lat = 1;
    bus.start = 1'b1; bus.fun = 4'h5;
    tick();
    bus.start = 1'b0;
    tick();
    bus.fifo_full = 1'b1;
    run_to(7);
    bus.fifo_full = 1'b0;
    run_to(13);
    check("full_nbytes", wr_byte.size(), 2);
    check("full_byte0", at8(wr_byte, 0), 32'hCD);
    check("full_byte1", at8(wr_byte, 1), 32'hAB);
    check("full_push_cyc0", ati(wr_cyc, 0), 32'd8);
    check("full_push_cyc1", ati(wr_cyc, 1), 32'd9);
    check("full_done_cyc", ati(done_cyc, 0), 32'd10);

    // start held while busy is ignored; nominal latency done at k+5
    clear_logs();
    alu_res = 16'h5A6B;
    bus.start = 1'b1; bus.fun = 4'h7;
    tick();
    bus.fun = 4'h3;
    run_to(3);
    bus.start = 1'b0;
    run_to(12);
    check("busy_start_done_count", done_cyc.size(), 1);
    check("busy_start_done_cyc", ati(done_cyc, 0), 32'd5);
    check("busy_start_en_count", en_cyc.size(), 1);
    check("busy_start_nbytes", wr_byte.size(), 2);
    check("busy_start_byte0", at8(wr_byte, 0), 32'h6B);
    check("busy_start_byte1", at8(wr_byte, 1), 32'h5A);
    check("busy_start_fun_held", {28'h0, bus.alu_fun}, 32'h7);

    // start on the done cycle is accepted
    clear_logs();
    alu_res = 16'h0102;
    bus.start = 1'b1; bus.fun = 4'h1;
    tick();
    bus.start = 1'b0;
    run_to(5);
    check("b2b_done_c5", {31'h0, bus.done}, 32'h1);
    bus.start = 1'b1; bus.fun = 4'h9;
    tick();
    bus.start = 1'b0;
    check("b2b_busy_c6", {31'h0, bus.busy}, 32'h1);
    check("b2b_alu_en_c6", {31'h0, bus.alu_en}, 32'h1);
    check("b2b_fun_c6", {28'h0, bus.alu_fun}, 32'h9);
    run_to(14);
    check("b2b_done_count", done_cyc.size(), 2);
    check("b2b_done_cyc1", ati(done_cyc, 1), 32'd10);
    check("b2b_nbytes", wr_byte.size(), 4);

    // Reset while stalled in PUSH_LO
    clear_logs();
    alu_res = 16'h7777;
    bus.start = 1'b1; bus.fun = 4'hC;
    tick();
    bus.start = 1'b0;
    tick();
    bus.fifo_full = 1'b1;
    run_to(6);
    check("rst_stall_busy", {31'h0, bus.busy}, 32'h1);
    check("rst_stall_nbytes", wr_byte.size(), 0);
    reset = 1'b0;
    #1;
    check("rst_mid_outputs", out_vec(), 32'h0);
    check("rst_mid_op_b", {24'h0, bus.alu_op_b}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    bus.fifo_full = 1'b0;
    clear_logs();
    run_to(6);
    check("rst_after_nbytes", wr_byte.size(), 0);
    check("rst_after_done", done_cyc.size(), 0);
    check("rst_after_busy", {31'h0, bus.busy}, 32'h0);

    // Fresh regfile fetch after reset
    clear_logs();
    rf_mem[0] = 8'hF0; rf_mem[1] = 8'h0F;
    alu_res = 16'h00FF;
    bus.start = 1'b1; bus.fun = 4'h4; bus.use_regs = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 60 && done_cyc.size() == 0; i++) tick();
    check("refetch_op_a", {24'h0, bus.alu_op_a}, 32'hF0);
    check("refetch_op_b", {24'h0, bus.alu_op_b}, 32'h0F);
    check("refetch_byte0", at8(wr_byte, 0), 32'hFF);
    check("refetch_byte1", at8(wr_byte, 1), 32'h00);

    // ALU never answers
    clear_logs();
    alu_never = 1'b1;
    bus.start = 1'b1; bus.fun = 4'h6; bus.use_regs = 1'b0;
    tick();
    bus.start = 1'b0;
    run_to(30);
`ifdef ALU_TIMEOUT_EN
    check("timeout_err_count", err_cyc.size(), 1);
    check("timeout_err_cyc", ati(err_cyc, 0), 32'd17);
    check("timeout_busy", {31'h0, bus.busy}, 32'h0);
`else
    check("no_timeout_err", err_cyc.size(), 0);
    check("no_timeout_busy", {31'h0, bus.busy}, 32'h1);
`endif
    check("stuck_nbytes", wr_byte.size(), 0);
    check("stuck_done", done_cyc.size(), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    alu_never = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
